// File: rtl/chroma_table_ctrl.sv
// rtl/chroma_table_ctrl.sv - chroma LUMA/PHASE/AMP tables with default loader and CPU config port (optional readback: CHROMA_TABLE_READBACK_EN)

module chroma_table_ctrl (
    input  logic       clk_dot4x,
    input  logic       rst,
    input  logic [1:0] chip,
    input  logic [3:0] pixel_color3,
    input  logic       cfg_req,
    input  logic       cfg_we,
    input  logic [5:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    output logic       cfg_ack,
    output logic [7:0] cfg_rdata,
    output logic       busy,
    output logic [5:0] lumareg_o,
    output logic [7:0] phasereg_o,
    output logic [3:0] amplitudereg_o
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_READY = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_init_idx;
    logic [3:0] w_init_idx_nxt;
    logic [1:0] r_chip;
    logic       w_chip_chg;
    logic       w_accept;
    logic       w_init_we;

    logic [5:0] r_luma_tab  [0:15];
    logic [7:0] r_phase_tab [0:15];
    logic [3:0] r_amp_tab   [0:15];

    logic [5:0] w_def_luma;
    logic [7:0] w_def_phase;
    logic [3:0] w_def_amp;

    logic       w_fwd;
    logic [5:0] w_rd_luma;
    logic [7:0] w_rd_phase;
    logic [3:0] w_rd_amp;

    logic [5:0] r_luma_q;
    logic [7:0] r_phase_q;
    logic [3:0] r_amp_q;

    // Any difference from the last sampled chip value restarts the loader.
    assign w_chip_chg = (chip != r_chip);

    // State register, loader index and the chip-select history.
    always_ff @(posedge clk_dot4x) begin
        r_chip <= chip;
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_idx <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_idx <= w_init_idx_nxt;
        end
    end

    // Next-state logic: loader sweep, request accept and single-cycle ack.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_idx_nxt = r_init_idx;
        w_accept       = 1'b0;
        w_init_we      = 1'b0;
        if (w_chip_chg) begin
            // A pending request is dropped here: no accept, no ack.
            w_state_nxt    = ST_INIT;
            w_init_idx_nxt = 4'd0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    w_init_we = 1'b1;
                    if (r_init_idx == 4'd15) begin
                        w_state_nxt    = ST_READY;
                        w_init_idx_nxt = 4'd0;
                    end else begin
                        w_init_idx_nxt = r_init_idx + 4'd1;
                    end
                end
                ST_READY: begin
                    if (cfg_req) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_ACK;
                    end
                end
                ST_ACK: begin
                    w_state_nxt = ST_READY;
                end
                default: begin
                    w_state_nxt    = ST_INIT;
                    w_init_idx_nxt = 4'd0;
                end
            endcase
        end
    end

    // Power-on defaults for the entry the loader writes this cycle.
    always_comb begin
        w_def_luma  = 6'd12 + {1'b0, r_init_idx, 1'b0} + {2'b00, r_init_idx};
        w_def_phase = {r_init_idx, 4'b0000} + (r_chip[0] ? 8'd8 : 8'd0);
        case (r_init_idx)
            4'd0, 4'd1, 4'd11, 4'd12, 4'd15: w_def_amp = 4'd0;
            default:                         w_def_amp = 4'd10;
        endcase
    end

    // Table writes: loader has the port during INIT, the CPU in READY.
    always_ff @(posedge clk_dot4x) begin
        if (!rst) begin
            if (w_init_we) begin
                r_luma_tab[r_init_idx]  <= w_def_luma;
                r_phase_tab[r_init_idx] <= w_def_phase;
                r_amp_tab[r_init_idx]   <= w_def_amp;
            end else if (w_accept && cfg_we) begin
                case (cfg_addr[5:4])
                    2'b00:   r_luma_tab[cfg_addr[3:0]]  <= cfg_wdata[5:0];
                    2'b01:   r_phase_tab[cfg_addr[3:0]] <= cfg_wdata;
                    2'b10:   r_amp_tab[cfg_addr[3:0]]   <= cfg_wdata[3:0];
                    default: ;
                endcase
            end
        end
    end

    // Pixel lookup; the loader's entry is forwarded so the first READY cycle is already correct.
    always_comb begin
        w_fwd      = w_init_we && (pixel_color3 == r_init_idx);
        w_rd_luma  = w_fwd ? w_def_luma  : r_luma_tab[pixel_color3];
        w_rd_phase = w_fwd ? w_def_phase : r_phase_tab[pixel_color3];
        w_rd_amp   = w_fwd ? w_def_amp   : r_amp_tab[pixel_color3];
    end

    // One-cycle lookup pipeline; CPU writes in the same cycle are seen next lookup.
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            r_luma_q  <= 6'd12;
            r_phase_q <= 8'd0;
            r_amp_q   <= 4'd0;
        end else begin
            r_luma_q  <= w_rd_luma;
            r_phase_q <= w_rd_phase;
            r_amp_q   <= w_rd_amp;
        end
    end

    assign busy           = (r_state == ST_INIT);
    assign cfg_ack        = (r_state == ST_ACK);
    assign lumareg_o      = busy ? 6'd12 : r_luma_q;
    assign phasereg_o     = busy ? 8'd0  : r_phase_q;
    assign amplitudereg_o = busy ? 4'd0  : r_amp_q;

`ifdef CHROMA_TABLE_READBACK_EN
    logic [7:0] r_rdata;
    logic [7:0] w_rb_data;

    // Zero-extended entry selected by the request address; reserved table reads 0.
    always_comb begin
        case (cfg_addr[5:4])
            2'b00:   w_rb_data = {2'b00, r_luma_tab[cfg_addr[3:0]]};
            2'b01:   w_rb_data = r_phase_tab[cfg_addr[3:0]];
            2'b10:   w_rb_data = {4'b0000, r_amp_tab[cfg_addr[3:0]]};
            default: w_rb_data = 8'd0;
        endcase
    end

    // Read data captured at accept, held until the next read is accepted.
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            r_rdata <= 8'd0;
        end else if (w_accept && !cfg_we) begin
            r_rdata <= w_rb_data;
        end
    end

    assign cfg_rdata = r_rdata;
`else
    assign cfg_rdata = 8'd0;
`endif

endmodule

// File: tb/tb_chroma_table_ctrl.sv
// tb/tb_chroma_table_ctrl.sv - self-checking bench for chroma_table_ctrl

module tb_chroma_table_ctrl;

`ifdef CHROMA_TABLE_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       clk_dot4x = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] chip = 2'b00;
    logic [3:0] pixel_color3 = 4'd0;
    logic       cfg_req = 1'b0;
    logic       cfg_we = 1'b0;
    logic [5:0] cfg_addr = 6'd0;
    logic [7:0] cfg_wdata = 8'd0;
    logic       cfg_ack;
    logic [7:0] cfg_rdata;
    logic       busy;
    logic [5:0] lumareg_o;
    logic [7:0] phasereg_o;
    logic [3:0] amplitudereg_o;

    chroma_table_ctrl dut (
        .clk_dot4x      (clk_dot4x),
        .rst            (rst),
        .chip           (chip),
        .pixel_color3   (pixel_color3),
        .cfg_req        (cfg_req),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_ack        (cfg_ack),
        .cfg_rdata      (cfg_rdata),
        .busy           (busy),
        .lumareg_o      (lumareg_o),
        .phasereg_o     (phasereg_o),
        .amplitudereg_o (amplitudereg_o)
    );

    always #5 clk_dot4x = ~clk_dot4x;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: tables as plain arrays, loader as a countdown.
    int         m_luma  [16];
    int         m_phase [16];
    int         m_amp   [16];
    int         m_init_left = 16;
    bit         m_ack = 1'b0;
    int         m_rdata = 0;
    logic [1:0] m_chip = 2'b00;
    int         m_q_luma = 12;
    int         m_q_phase = 0;
    int         m_q_amp = 0;

    typedef struct {
        int pix;
        int req;
        int we;
        int addr;
        int wdata;
        int ack;
        int rdata;
        int luma;
        int phase;
        int amp;
    } vec_t;

    vec_t vecs [20];

    function automatic int def_luma(input int k);
        return 12 + 3 * k;
    endfunction

    function automatic int def_phase(input int k, input bit pal);
        return (16 * k + (pal ? 8 : 0)) % 256;
    endfunction

    function automatic int def_amp(input int k);
        return (k == 0 || k == 1 || k == 11 || k == 12 || k == 15) ? 0 : 10;
    endfunction

    function automatic vec_t mk(input int pix, input int req, input int we, input int addr,
                                input int wdata, input int ack, input int rdata,
                                input int luma, input int phase, input int amp);
        vec_t v;
        v.pix = pix; v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
        v.ack = ack; v.rdata = rdata; v.luma = luma; v.phase = phase; v.amp = amp;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        int k;
        bit chg;
        if (rst) begin
            m_init_left = 16;
            m_ack       = 1'b0;
            m_rdata     = 0;
            m_chip      = chip;
        end else begin
            k   = 16 - m_init_left;
            chg = (chip != m_chip);
            if (m_init_left > 0 && !chg && int'(pixel_color3) == k) begin
                m_q_luma  = def_luma(k);
                m_q_phase = def_phase(k, m_chip[0]);
                m_q_amp   = def_amp(k);
            end else begin
                m_q_luma  = m_luma[pixel_color3];
                m_q_phase = m_phase[pixel_color3];
                m_q_amp   = m_amp[pixel_color3];
            end
            if (chg) begin
                m_init_left = 16;
                m_ack       = 1'b0;
            end else if (m_init_left > 0) begin
                m_luma[k]  = def_luma(k);
                m_phase[k] = def_phase(k, m_chip[0]);
                m_amp[k]   = def_amp(k);
                m_init_left--;
            end else if (m_ack) begin
                m_ack = 1'b0;
            end else if (cfg_req) begin
                m_ack = 1'b1;
                if (cfg_we) begin
                    case (cfg_addr[5:4])
                        2'b00:   m_luma[cfg_addr[3:0]]  = int'(cfg_wdata) % 64;
                        2'b01:   m_phase[cfg_addr[3:0]] = int'(cfg_wdata);
                        2'b10:   m_amp[cfg_addr[3:0]]   = int'(cfg_wdata) % 16;
                        default: ;
                    endcase
                end else if (RB) begin
                    case (cfg_addr[5:4])
                        2'b00:   m_rdata = m_luma[cfg_addr[3:0]];
                        2'b01:   m_rdata = m_phase[cfg_addr[3:0]];
                        2'b10:   m_rdata = m_amp[cfg_addr[3:0]];
                        default: m_rdata = 0;
                    endcase
                end
            end
            m_chip = chip;
        end
    endtask

    task automatic tick();
        @(posedge clk_dot4x);
        model_step();
        @(negedge clk_dot4x);
    endtask

    task automatic check_model(input int cyc);
        int eb;
        eb = (m_init_left > 0) ? 1 : 0;
        chk($sformatf("rand%0d_busy", cyc), busy, eb);
        chk($sformatf("rand%0d_ack", cyc), cfg_ack, m_ack);
        chk($sformatf("rand%0d_rdata", cyc), cfg_rdata, m_rdata);
        chk($sformatf("rand%0d_luma", cyc), lumareg_o, eb ? 12 : m_q_luma);
        chk($sformatf("rand%0d_phase", cyc), phasereg_o, eb ? 0 : m_q_phase);
        chk($sformatf("rand%0d_amp", cyc), amplitudereg_o, eb ? 0 : m_q_amp);
    endtask

    task automatic wait_busy_low(input int limit, output int n_busy, output int n_ack);
        n_busy = 0;
        n_ack  = 0;
        while (busy && n_busy < limit) begin
            n_busy++;
            if (cfg_ack) n_ack++;
            tick();
        end
    endtask

    initial begin
        int nb;
        int na;
        int n;
        int r12;

        for (int i = 0; i < 16; i++) begin
            m_luma[i] = 0; m_phase[i] = 0; m_amp[i] = 0;
        end

        // Reset state.
        repeat (3) tick();
        chk("reset_busy", busy, 1);
        chk("reset_ack", cfg_ack, 0);
        chk("reset_rdata", cfg_rdata, 0);
        chk("reset_luma", lumareg_o, 12);
        chk("reset_phase", phasereg_o, 0);
        chk("reset_amp", amplitudereg_o, 0);

        // Release reset with a read of LUMA[0] already pending; it must stall until READY.
        rst = 1'b0; cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 6'h00; pixel_color3 = 4'd5;
        wait_busy_low(40, nb, na);
        chk("init_busy_cycles", nb, 16);
        chk("init_stalled_ack", na, 0);
        chk("ready_no_ack_yet", cfg_ack, 0);
        n = 0;
        while (!cfg_ack && n < 8) begin
            tick();
            n++;
        end
        chk("stalled_ack_latency", 1 + n, 2);
        r12 = RB ? 12 : 0;
        chk("stalled_read_rdata", cfg_rdata, r12);
        cfg_req = 1'b0;
        tick();
        chk("ack_one_cycle", cfg_ack, 0);

        // Directed vectors in READY with NTSC defaults loaded.
        vecs[0]  = mk(5,  0, 0, 'h00, 'h00, 0, r12,            27, 80,  10);
        vecs[1]  = mk(0,  0, 0, 'h00, 'h00, 0, r12,            12, 0,   0);
        vecs[2]  = mk(15, 0, 0, 'h00, 'h00, 0, r12,            57, 240, 0);
        vecs[3]  = mk(11, 0, 0, 'h00, 'h00, 0, r12,            45, 176, 0);
        vecs[4]  = mk(3,  1, 1, 'h13, 'hA5, 1, r12,            21, 48,  10);
        vecs[5]  = mk(3,  0, 0, 'h00, 'h00, 0, r12,            21, 165, 10);
        vecs[6]  = mk(2,  1, 1, 'h02, 'hFF, 1, r12,            18, 32,  10);
        vecs[7]  = mk(2,  0, 0, 'h00, 'h00, 0, r12,            63, 32,  10);
        vecs[8]  = mk(5,  1, 1, 'h25, 'h37, 1, r12,            27, 80,  10);
        vecs[9]  = mk(5,  0, 0, 'h00, 'h00, 0, r12,            27, 80,  7);
        vecs[10] = mk(6,  1, 1, 'h30, 'hFF, 1, r12,            30, 96,  10);
        vecs[11] = mk(6,  0, 0, 'h00, 'h00, 0, r12,            30, 96,  10);
        vecs[12] = mk(0,  1, 0, 'h13, 'h00, 1, RB ? 'hA5 : 0,  12, 0,   0);
        vecs[13] = mk(0,  0, 0, 'h00, 'h00, 0, RB ? 'hA5 : 0,  12, 0,   0);
        vecs[14] = mk(0,  1, 0, 'h3A, 'h00, 1, 0,              12, 0,   0);
        vecs[15] = mk(9,  0, 0, 'h00, 'h00, 0, 0,              39, 144, 10);
        vecs[16] = mk(9,  1, 0, 'h02, 'h00, 1, RB ? 63 : 0,    39, 144, 10);
        vecs[17] = mk(9,  1, 0, 'h25, 'h00, 0, RB ? 63 : 0,    39, 144, 10);
        vecs[18] = mk(9,  1, 0, 'h25, 'h00, 1, RB ? 7 : 0,     39, 144, 10);
        vecs[19] = mk(9,  0, 0, 'h00, 'h00, 0, RB ? 7 : 0,     39, 144, 10);

        for (int i = 0; i < 20; i++) begin
            pixel_color3 = 4'(vecs[i].pix);
            cfg_req      = 1'(vecs[i].req);
            cfg_we       = 1'(vecs[i].we);
            cfg_addr     = 6'(vecs[i].addr);
            cfg_wdata    = 8'(vecs[i].wdata);
            tick();
            chk($sformatf("vec%0d_busy", i), busy, 0);
            chk($sformatf("vec%0d_ack", i), cfg_ack, vecs[i].ack);
            chk($sformatf("vec%0d_rdata", i), cfg_rdata, vecs[i].rdata);
            chk($sformatf("vec%0d_luma", i), lumareg_o, vecs[i].luma);
            chk($sformatf("vec%0d_phase", i), phasereg_o, vecs[i].phase);
            chk($sformatf("vec%0d_amp", i), amplitudereg_o, vecs[i].amp);
        end

        // Switch to PAL: loader reruns and overwrites the CPU edits.
        cfg_req = 1'b0; chip = 2'b01; pixel_color3 = 4'd15;
        tick();
        chk("pal_busy_start", busy, 1);
        chk("pal_blank_luma", lumareg_o, 12);
        wait_busy_low(40, nb, na);
        chk("pal_busy_cycles", nb, 16);
        chk("pal_luma15", lumareg_o, 57);
        chk("pal_phase15", phasereg_o, 248);
        chk("pal_amp15", amplitudereg_o, 0);
        pixel_color3 = 4'd3;
        tick();
        chk("pal_phase3", phasereg_o, 56);
        chk("pal_luma3", lumareg_o, 21);

        // Chip toggle while a write is being requested: dropped, loader restarts blank.
        chip = 2'b00; cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 6'h01; cfg_wdata = 8'h3F;
        pixel_color3 = 4'd1;
        tick();
        chk("toggle_ack", cfg_ack, 0);
        chk("toggle_busy", busy, 1);
        chk("toggle_luma", lumareg_o, 12);
        chk("toggle_phase", phasereg_o, 0);
        chk("toggle_amp", amplitudereg_o, 0);
        cfg_req = 1'b0;
        wait_busy_low(40, nb, na);
        chk("toggle_busy_cycles", nb, 16);
        chk("toggle_dropped_ack", na, 0);
        tick();
        chk("toggle_after_ack", cfg_ack, 0);
        chk("toggle_luma1", lumareg_o, 15);
        chk("toggle_phase1", phasereg_o, 16);

        // Randomized traffic against the reference model, including mid-INIT resets and chip changes.
        for (int c = 0; c < 600; c++) begin
            rst          = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 3) chip = 2'($urandom_range(0, 3));
            pixel_color3 = 4'($urandom_range(0, 15));
            cfg_req      = 1'($urandom_range(0, 1));
            cfg_we       = 1'($urandom_range(0, 1));
            cfg_addr     = 6'($urandom_range(0, 63));
            cfg_wdata    = 8'($urandom_range(0, 255));
            tick();
            check_model(c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
